instr_fetch: RTL and testbench

Fetch/decode stage directly upstream of the instruction queue. Reads one 32-bit instruction at a time from the instruction-memory port, decodes it into a `tomasula_types::ctl_word` plus an rvfi record, and offers it to the queue with a hold-until-ack handshake. The PC advances sequentially by 4; a flush from the commit side redirects it, including while a memory read is outstanding.

---
 rtl/rv32i_types.sv | 23 ++
 rtl/tomasula_types.sv | 47 ++++
 rtl/instr_decode.sv | 91 +++++++++
 rtl/instr_fetch.sv | 136 +++++++++++++
 tb/tb_instr_fetch.sv | 494 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_types.sv
// RV32I constants shared by the fetch stage: base opcodes, fetch FSM states
// and the default reset vector.
package rv32i_types;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h4000_0000;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/tomasula_types.sv
// Back-end types: op encoding, control word handed to the instruction queue,
// and the rvfi monitor record.
package tomasula_types;

    localparam logic [4:0] OP_STORE_MIN = 5'd8;
    localparam logic [4:0] OP_LOAD_MIN  = 5'd11;

    // ALU ops follow funct3; stores and loads occupy contiguous ranges above.
    typedef enum logic [4:0] {
        OP_ADD    = 5'd0,
        OP_SLL    = 5'd1,
        OP_SLT    = 5'd2,
        OP_SLTU   = 5'd3,
        OP_XOR    = 5'd4,
        OP_SR     = 5'd5,
        OP_OR     = 5'd6,
        OP_AND    = 5'd7,
        OP_SB     = 5'd8,
        OP_SH     = 5'd9,
        OP_SW     = 5'd10,
        OP_LB     = 5'd11,
        OP_LH     = 5'd12,
        OP_LW     = 5'd13,
        OP_LBU    = 5'd14,
        OP_LHU    = 5'd15,
        OP_BRANCH = 5'd16
    } op_t;

    typedef struct packed {
        op_t         op;
        logic [31:0] og_pc;
        logic [31:0] og_instr;
        logic [31:0] pc;
        logic [2:0]  funct3;
        logic        funct7;
        logic        src1_valid;
        logic        src2_valid;
        logic [31:0] src2_data;
    } ctl_word;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_rdata;
        logic [31:0] pc_wdata;
    } rvfi_word;

endpackage

// File: rtl/instr_decode.sv
// Combinational RV32I decoder: instruction + PC in, control word + rvfi out.
// Unsupported encodings become ADD with no sources and a zero immediate.
module instr_decode
    import rv32i_types::*;
    import tomasula_types::*;
(
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    output ctl_word     ctl_o,
    output rvfi_word    rvfi_o
);

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    assign opcode = instr_i[6:0];
    assign f3     = instr_i[14:12];
    assign imm_i  = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_s  = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b  = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign imm_u  = {instr_i[31:12], 12'h000};
    assign imm_j  = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

    always_comb begin
        ctl_o          = '0;
        ctl_o.op       = OP_ADD;
        ctl_o.og_pc    = pc_i;
        ctl_o.og_instr = instr_i;
        ctl_o.pc       = pc_i + 32'd4;
        ctl_o.funct3   = f3;
        ctl_o.funct7   = instr_i[30];
        case (opcode)
            OPC_LUI, OPC_AUIPC: begin
                ctl_o.src2_data = imm_u;
            end
            OPC_JAL: begin
                ctl_o.op        = OP_BRANCH;
                ctl_o.src2_data = imm_j;
            end
            OPC_JALR: begin
                ctl_o.op         = OP_BRANCH;
                ctl_o.src1_valid = 1'b1;
                ctl_o.src2_data  = imm_i;
            end
            OPC_BRANCH: begin
                ctl_o.op         = OP_BRANCH;
                ctl_o.src1_valid = 1'b1;
                ctl_o.src2_valid = 1'b1;
                ctl_o.src2_data  = imm_b;
            end
            OPC_LOAD: begin
                // lb/lh/lw/lbu/lhu pack densely; funct3 3, 6 and 7 are illegal.
                if (f3 != 3'd3 && f3 < 3'd6) begin
                    ctl_o.op         = op_t'(OP_LOAD_MIN + {2'b00, f3} - {4'b0000, f3[2]});
                    ctl_o.src1_valid = 1'b1;
                    ctl_o.src2_data  = imm_i;
                end
            end
            OPC_STORE: begin
                if (f3 <= 3'd2) begin
                    ctl_o.op         = op_t'(OP_STORE_MIN + {2'b00, f3});
                    ctl_o.src1_valid = 1'b1;
                    ctl_o.src2_valid = 1'b1;
                    ctl_o.src2_data  = imm_s;
                end
            end
            OPC_OP_IMM: begin
                ctl_o.op         = op_t'({2'b00, f3});
                ctl_o.src1_valid = 1'b1;
                ctl_o.src2_data  = imm_i;
            end
            OPC_OP: begin
                ctl_o.op         = op_t'({2'b00, f3});
                ctl_o.src1_valid = 1'b1;
                ctl_o.src2_valid = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign rvfi_o.instr    = instr_i;
    assign rvfi_o.pc_rdata = pc_i;
    assign rvfi_o.pc_wdata = pc_i + 32'd4;

endmodule

// File: rtl/instr_fetch.sv
// Fetch/decode stage feeding the instruction queue; one imem read in flight.
// Define IF_PERF_CNT_EN to add the perf_fetched / perf_stall counters.
module instr_fetch
    import rv32i_types::*;
    import tomasula_types::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        imem_read,
    output logic [31:0] imem_address,
    input  logic [31:0] imem_rdata,
    input  logic        imem_resp,
    output logic        ld_iq,
    output ctl_word     control_word,
    output rvfi_word    rvfi,
    input  logic        ack_i
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`endif
);

    // Queue handshake: ld_iq is valid, ack_i is ready. Once ld_iq rises the
    // word is held unchanged until the cycle ack_i is high; ack_i is ignored
    // whenever ld_iq is low.

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    ctl_word      dec_ctl;
    rvfi_word     dec_rvfi;

    instr_decode u_decode (
        .instr_i (instr_q),
        .pc_i    (pc_q),
        .ctl_o   (dec_ctl),
        .rvfi_o  (dec_rvfi)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        instr_d         = instr_q;
        imem_read       = 1'b0;
        ld_iq           = 1'b0;
        control_word    = '0;
        control_word.op = OP_BRANCH;
        rvfi            = '0;
        case (state_q)
            FETCH: begin
                imem_read = !rst;
                if (flush) begin
                    // A response in the flush cycle ends the old read, so no drain is needed.
                    pc_d    = flush_pc;
                    state_d = imem_resp ? FETCH : DRAIN;
                end else if (imem_resp) begin
                    instr_d = imem_rdata;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                ld_iq        = 1'b1;
                control_word = dec_ctl;
                rvfi         = dec_rvfi;
                if (flush) begin
                    pc_d    = flush_pc;
                    state_d = FETCH;
                end else if (ack_i) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = FETCH;
                end
            end
            DRAIN: begin
                imem_read = !rst;
                if (flush) begin
                    pc_d = flush_pc;
                end else if (imem_resp) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    assign imem_address = pc_q;

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetched_q, fetched_d;
    logic [31:0] stall_q, stall_d;

    always_comb begin
        fetched_d = fetched_q;
        stall_d   = stall_q;
        if (state_q == ISSUE) begin
            if (ack_i) begin
                if (fetched_q != 32'hFFFF_FFFF) fetched_d = fetched_q + 32'd1;
            end else begin
                if (stall_q != 32'hFFFF_FFFF) stall_d = stall_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetched_q <= '0;
            stall_q   <= '0;
        end else begin
            fetched_q <= fetched_d;
            stall_q   <= stall_d;
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_stall   = stall_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed fetch/flush/reset scenarios
// plus randomly encoded instructions checked against a field-level model.
module tb_instr_fetch;
    import rv32i_types::*;
    import tomasula_types::*;

    localparam int K_LUI = 0, K_AUIPC = 1, K_JAL = 2, K_JALR = 3, K_BR = 4;
    localparam int K_LD = 5, K_ST = 6, K_OPI = 7, K_OP = 8, K_ILL = 9;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [31:0] flush_pc;
    logic        imem_read;
    logic [31:0] imem_address;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic        ld_iq;
    ctl_word     control_word;
    rvfi_word    rvfi;
    logic        ack_i;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    int          passed = 0;
    int          total = 0;
    logic [31:0] exp_pc;
    int          exp_fetched;
    int          exp_stall;

    always #5 clk = ~clk;

    instr_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .flush_pc     (flush_pc),
        .imem_read    (imem_read),
        .imem_address (imem_address),
        .imem_rdata   (imem_rdata),
        .imem_resp    (imem_resp),
        .ld_iq        (ld_iq),
        .control_word (control_word),
        .rvfi         (rvfi),
        .ack_i        (ack_i)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_stall   (perf_stall)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Assemble an instruction from its fields; imm is the architectural immediate value.
    function automatic logic [31:0] enc(input int kind, input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [31:0] imm, input logic b30);
        case (kind)
            K_LUI:   return {imm[31:12], rd, OPC_LUI};
            K_AUIPC: return {imm[31:12], rd, OPC_AUIPC};
            K_JAL:   return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
            K_JALR:  return {imm[11:0], rs1, 3'b000, rd, OPC_JALR};
            K_BR:    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OPC_BRANCH};
            K_LD:    return {imm[11:0], rs1, f3, rd, OPC_LOAD};
            K_ST:    return {imm[11:5], rs2, rs1, f3, imm[4:0], OPC_STORE};
            K_OPI:   return {imm[11:0], rs1, f3, rd, OPC_OP_IMM};
            K_OP:    return {1'b0, b30, 5'b00000, rs2, rs1, f3, rd, OPC_OP};
            default: return 32'h0;
        endcase
    endfunction

    function automatic op_t alu_op(input logic [2:0] f3);
        case (f3)
            3'd0: return OP_ADD;
            3'd1: return OP_SLL;
            3'd2: return OP_SLT;
            3'd3: return OP_SLTU;
            3'd4: return OP_XOR;
            3'd5: return OP_SR;
            3'd6: return OP_OR;
            default: return OP_AND;
        endcase
    endfunction

    // Expected control word from the instruction class and its known immediate.
    function automatic ctl_word model_cw(input int kind, input logic [31:0] instr,
                                         input logic [31:0] imm, input logic [31:0] pc);
        ctl_word c;
        logic [2:0] f3;
        f3 = instr[14:12];
        c = '0;
        c.op = OP_ADD;
        c.og_pc = pc;
        c.og_instr = instr;
        c.pc = pc + 32'd4;
        c.funct3 = f3;
        c.funct7 = instr[30];
        case (kind)
            K_LUI, K_AUIPC: c.src2_data = imm;
            K_JAL: begin c.op = OP_BRANCH; c.src2_data = imm; end
            K_JALR: begin c.op = OP_BRANCH; c.src1_valid = 1'b1; c.src2_data = imm; end
            K_BR: begin c.op = OP_BRANCH; c.src1_valid = 1'b1; c.src2_valid = 1'b1; c.src2_data = imm; end
            K_LD: begin
                case (f3)
                    3'd0: c.op = OP_LB;
                    3'd1: c.op = OP_LH;
                    3'd2: c.op = OP_LW;
                    3'd4: c.op = OP_LBU;
                    default: c.op = OP_LHU;
                endcase
                c.src1_valid = 1'b1;
                c.src2_data = imm;
            end
            K_ST: begin
                c.op = (f3 == 3'd0) ? OP_SB : (f3 == 3'd1) ? OP_SH : OP_SW;
                c.src1_valid = 1'b1;
                c.src2_valid = 1'b1;
                c.src2_data = imm;
            end
            K_OPI: begin c.op = alu_op(f3); c.src1_valid = 1'b1; c.src2_data = imm; end
            K_OP: begin c.op = alu_op(f3); c.src1_valid = 1'b1; c.src2_valid = 1'b1; end
            default: begin end
        endcase
        return c;
    endfunction

    task automatic gen_random(output logic [31:0] instr, output logic [31:0] imm, output int kind);
        logic [2:0] f3;
        logic [4:0] rd, rs1, rs2;
        kind = int'($urandom_range(0, 9));
        f3 = 3'($urandom_range(0, 7));
        rd = 5'($urandom);
        rs1 = 5'($urandom);
        rs2 = 5'($urandom);
        imm = $urandom_range(0, 4095) - 32'd2048;
        case (kind)
            K_LUI, K_AUIPC: imm = {20'($urandom), 12'h000};
            K_JAL: imm = ($urandom_range(0, 1048575) << 1) - 32'd1048576;
            K_BR: imm = ($urandom_range(0, 4095) << 1) - 32'd4096;
            K_LD: case ($urandom_range(0, 4))
                0: f3 = 3'd0;
                1: f3 = 3'd1;
                2: f3 = 3'd2;
                3: f3 = 3'd4;
                default: f3 = 3'd5;
            endcase
            K_ST: f3 = 3'($urandom_range(0, 2));
            K_OP: imm = 32'h0;
            default: begin end
        endcase
        if (kind == K_ILL) begin
            imm = 32'h0;
            case ($urandom_range(0, 2))
                0: begin
                    instr = $urandom;
                    case ($urandom_range(0, 3))
                        0: instr[6:0] = 7'h00;
                        1: instr[6:0] = 7'h7F;
                        2: instr[6:0] = 7'h2F;
                        default: instr[6:0] = 7'h0B;
                    endcase
                end
                1: instr = enc(K_LD, ($urandom_range(0, 2) == 0) ? 3'd3 : 3'd6 + 3'($urandom_range(0, 1)),
                               rd, rs1, rs2, 32'($urandom_range(0, 4095)), 1'b0);
                default: instr = enc(K_ST, 3'($urandom_range(3, 7)), rd, rs1, rs2,
                                     32'($urandom_range(0, 4095)), 1'b0);
            endcase
        end else begin
            instr = enc(kind, f3, rd, rs1, rs2, imm, 1'($urandom_range(0, 1)));
        end
    endtask

    // Full fetch -> issue -> ack of one instruction starting in FETCH at exp_pc.
    task automatic run_instr(input logic [31:0] instr, input int kind, input logic [31:0] imm,
                             input int lat, input int stall);
        ctl_word exp_c;
        rvfi_word exp_r;
        exp_c = model_cw(kind, instr, imm, exp_pc);
        exp_r.instr = instr;
        exp_r.pc_rdata = exp_pc;
        exp_r.pc_wdata = exp_pc + 32'd4;
        total++;
        if (imem_read !== 1'b1 || imem_address !== exp_pc)
            $display("FAIL fetch_req: read=%b addr=%h, want read=1 addr=%h", imem_read, imem_address, exp_pc);
        else passed++;
        for (int i = 0; i < lat; i++) begin
            ack_i = 1'($urandom_range(0, 1));
            tick();
            total++;
            if (imem_read !== 1'b1 || imem_address !== exp_pc || ld_iq !== 1'b0)
                $display("FAIL fetch_wait: read=%b addr=%h ld_iq=%b, want 1 %h 0", imem_read, imem_address, ld_iq, exp_pc);
            else passed++;
        end
        ack_i = 1'b0;
        imem_resp = 1'b1;
        imem_rdata = instr;
        tick();
        imem_resp = 1'b0;
        imem_rdata = $urandom;
        total++;
        if (ld_iq !== 1'b1 || imem_read !== 1'b0)
            $display("FAIL issue: ld_iq=%b read=%b, want ld_iq=1 read=0", ld_iq, imem_read);
        else passed++;
        total++;
        if (control_word !== exp_c)
            $display("FAIL ctl_word: instr=%h got %h want %h", instr, control_word, exp_c);
        else passed++;
        total++;
        if (rvfi !== exp_r) $display("FAIL rvfi: got %h want %h", rvfi, exp_r);
        else passed++;
        if (kind == K_ST || kind == K_LD) begin
            total++;
            if ((kind == K_ST && (control_word.op < 5'd8 || control_word.op > 5'd10)) ||
                (kind == K_LD && control_word.op < 5'd11))
                $display("FAIL op_range: kind=%0d op=%0d", kind, control_word.op);
            else passed++;
        end
        for (int i = 0; i < stall; i++) begin
            tick();
            exp_stall++;
            total++;
            if (ld_iq !== 1'b1 || control_word !== exp_c)
                $display("FAIL hold: ld_iq=%b cw=%h, want 1 %h", ld_iq, control_word, exp_c);
            else passed++;
        end
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        exp_pc = exp_pc + 32'd4;
        exp_fetched++;
        total++;
        if (imem_read !== 1'b1 || imem_address !== exp_pc || ld_iq !== 1'b0)
            $display("FAIL after_ack: read=%b addr=%h ld_iq=%b, want 1 %h 0", imem_read, imem_address, ld_iq, exp_pc);
        else passed++;
`ifdef IF_PERF_CNT_EN
        total++;
        if (perf_fetched !== 32'(exp_fetched) || perf_stall !== 32'(exp_stall))
            $display("FAIL perf: fetched=%0d stall=%0d, want %0d %0d", perf_fetched, perf_stall, exp_fetched, exp_stall);
        else passed++;
`endif
    endtask

    task automatic test_reset();
        ctl_word idle;
        idle = '0;
        idle.op = OP_BRANCH;
        rst = 1'b1;
        flush = 1'b0;
        flush_pc = 32'h0;
        imem_resp = 1'b0;
        imem_rdata = 32'h0;
        ack_i = 1'b0;
        tick();
        tick();
        total++;
        if (imem_read !== 1'b0 || imem_address !== 32'h4000_0000 || ld_iq !== 1'b0)
            $display("FAIL reset_ports: read=%b addr=%h ld_iq=%b, want 0 40000000 0", imem_read, imem_address, ld_iq);
        else passed++;
        total++;
        if (control_word !== idle || rvfi !== '0)
            $display("FAIL reset_cw: cw=%h rvfi=%h, want %h 0", control_word, rvfi, idle);
        else passed++;
`ifdef IF_PERF_CNT_EN
        total++;
        if (perf_fetched !== 32'h0 || perf_stall !== 32'h0)
            $display("FAIL reset_perf: %0d %0d", perf_fetched, perf_stall);
        else passed++;
`endif
        rst = 1'b0;
        tick();
        exp_pc = 32'h4000_0000;
        exp_fetched = 0;
        exp_stall = 0;
        total++;
        if (imem_read !== 1'b1 || imem_address !== 32'h4000_0000)
            $display("FAIL post_reset: read=%b addr=%h, want 1 40000000", imem_read, imem_address);
        else passed++;
    endtask

    task automatic test_first_fetch();
        repeat (3) begin
            tick();
            total++;
            if (imem_read !== 1'b1 || imem_address !== 32'h4000_0000 || ld_iq !== 1'b0)
                $display("FAIL first_wait: read=%b addr=%h ld_iq=%b", imem_read, imem_address, ld_iq);
            else passed++;
        end
        imem_resp = 1'b1;
        imem_rdata = 32'h0050_0093;
        tick();
        imem_resp = 1'b0;
        total++;
        if (ld_iq !== 1'b1) $display("FAIL first_ld_iq: got %b want 1", ld_iq);
        else passed++;
        total++;
        if (control_word.og_pc !== 32'h4000_0000 || control_word.pc !== 32'h4000_0004)
            $display("FAIL first_pc: og_pc=%h pc=%h, want 40000000 40000004", control_word.og_pc, control_word.pc);
        else passed++;
        total++;
        if (control_word.src2_data !== 32'd5 || control_word.src1_valid !== 1'b1 ||
            control_word.src2_valid !== 1'b0 || control_word.op !== OP_ADD)
            $display("FAIL first_fields: imm=%h s1=%b s2=%b op=%0d, want 5 1 0 0", control_word.src2_data,
                     control_word.src1_valid, control_word.src2_valid, control_word.op);
        else passed++;
    endtask

    task automatic test_stall_ack();
        ctl_word exp_c;
        exp_c = model_cw(K_OPI, 32'h0050_0093, 32'd5, 32'h4000_0000);
        repeat (4) begin
            tick();
            exp_stall++;
            total++;
            if (ld_iq !== 1'b1 || control_word !== exp_c)
                $display("FAIL stall_hold: ld_iq=%b cw=%h want %h", ld_iq, control_word, exp_c);
            else passed++;
        end
`ifdef IF_PERF_CNT_EN
        total++;
        if (perf_stall !== 32'd4) $display("FAIL perf_stall: got %0d want 4", perf_stall);
        else passed++;
`endif
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        exp_pc = 32'h4000_0004;
        exp_fetched++;
        total++;
        if (imem_read !== 1'b1 || imem_address !== 32'h4000_0004 || ld_iq !== 1'b0)
            $display("FAIL ack_advance: read=%b addr=%h ld_iq=%b, want 1 40000004 0", imem_read, imem_address, ld_iq);
        else passed++;
    endtask

    task automatic test_flush_drain();
        logic [31:0] instr, imm;
        int kind;
        tick();
        flush = 1'b1;
        flush_pc = 32'h4000_0100;
        tick();
        flush = 1'b0;
        exp_pc = 32'h4000_0100;
        repeat (2) begin
            total++;
            if (imem_read !== 1'b1 || imem_address !== exp_pc || ld_iq !== 1'b0)
                $display("FAIL drain_wait: read=%b addr=%h ld_iq=%b, want 1 %h 0", imem_read, imem_address, ld_iq, exp_pc);
            else passed++;
            tick();
        end
        imem_resp = 1'b1;
        imem_rdata = 32'h0010_0093;
        tick();
        imem_resp = 1'b0;
        repeat (2) begin
            total++;
            if (ld_iq !== 1'b0 || imem_read !== 1'b1 || imem_address !== exp_pc)
                $display("FAIL drain_discard: ld_iq=%b read=%b addr=%h, want 0 1 %h", ld_iq, imem_read, imem_address, exp_pc);
            else passed++;
            tick();
        end
        gen_random(instr, imm, kind);
        run_instr(instr, kind, imm, 1, 0);
    endtask

    task automatic test_flush_same_cycle();
        logic [31:0] instr, imm;
        int kind;
        tick();
        imem_resp = 1'b1;
        imem_rdata = 32'h0020_0113;
        flush = 1'b1;
        flush_pc = 32'h4000_0200;
        tick();
        imem_resp = 1'b0;
        flush = 1'b0;
        exp_pc = 32'h4000_0200;
        total++;
        if (ld_iq !== 1'b0 || imem_read !== 1'b1 || imem_address !== exp_pc)
            $display("FAIL flush_resp: ld_iq=%b read=%b addr=%h, want 0 1 %h", ld_iq, imem_read, imem_address, exp_pc);
        else passed++;
        gen_random(instr, imm, kind);
        run_instr(instr, kind, imm, 0, 0);
    endtask

    task automatic test_flush_issue();
        logic [31:0] instr, imm;
        int kind;
        for (int k = 0; k < 2; k++) begin
            gen_random(instr, imm, kind);
            imem_resp = 1'b1;
            imem_rdata = instr;
            tick();
            imem_resp = 1'b0;
            total++;
            if (ld_iq !== 1'b1) $display("FAIL flush_issue_pre: ld_iq=%b want 1", ld_iq);
            else passed++;
            ack_i = 1'(k);
            flush = 1'b1;
            flush_pc = 32'h4000_0300 + 32'(k * 16);
            tick();
            flush = 1'b0;
            ack_i = 1'b0;
            if (k == 1) exp_fetched++;
            else exp_stall++;
            exp_pc = 32'h4000_0300 + 32'(k * 16);
            total++;
            if (ld_iq !== 1'b0 || imem_read !== 1'b1 || imem_address !== exp_pc)
                $display("FAIL flush_issue: k=%0d ld_iq=%b read=%b addr=%h, want 0 1 %h", k, ld_iq, imem_read, imem_address, exp_pc);
            else passed++;
        end
        // Second flush while already draining retargets the PC again.
        flush = 1'b1;
        flush_pc = 32'h4000_0400;
        tick();
        flush_pc = 32'h4000_0500;
        tick();
        flush = 1'b0;
        exp_pc = 32'h4000_0500;
        total++;
        if (imem_read !== 1'b1 || imem_address !== exp_pc)
            $display("FAIL drain_reflush: read=%b addr=%h, want 1 %h", imem_read, imem_address, exp_pc);
        else passed++;
        imem_resp = 1'b1;
        imem_rdata = 32'h0030_0193;
        tick();
        imem_resp = 1'b0;
        total++;
        if (ld_iq !== 1'b0) $display("FAIL drain_reflush_discard: ld_iq=%b want 0", ld_iq);
        else passed++;
        gen_random(instr, imm, kind);
        run_instr(instr, kind, imm, 2, 1);
    endtask

    task automatic test_decode_sweep();
        logic [31:0] instr, imm;
        int kind;
        run_instr(32'h0020_A423, K_ST, 32'd8, 1, 0);
        run_instr(enc(K_LD, 3'd2, 5'd3, 5'd1, 5'd0, 32'hFFFF_FFFC, 1'b0), K_LD, 32'hFFFF_FFFC, 0, 1);
        run_instr(enc(K_BR, 3'd0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFF0, 1'b0), K_BR, 32'hFFFF_FFF0, 2, 0);
        run_instr(enc(K_LUI, 3'd0, 5'd5, 5'd0, 5'd0, 32'hABCD_E000, 1'b0), K_LUI, 32'hABCD_E000, 0, 0);
        for (int n = 0; n < 60; n++) begin
            gen_random(instr, imm, kind);
            run_instr(instr, kind, imm, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
        end
    endtask

    task automatic test_reset_in_issue();
        logic [31:0] instr, imm;
        int kind;
        gen_random(instr, imm, kind);
        imem_resp = 1'b1;
        imem_rdata = instr;
        tick();
        imem_resp = 1'b0;
        total++;
        if (ld_iq !== 1'b1) $display("FAIL rst_issue_pre: ld_iq=%b want 1", ld_iq);
        else passed++;
        rst = 1'b1;
        ack_i = 1'($urandom_range(0, 1));
        tick();
        ack_i = 1'b0;
        total++;
        if (ld_iq !== 1'b0 || imem_read !== 1'b0 || imem_address !== 32'h4000_0000)
            $display("FAIL rst_issue: ld_iq=%b read=%b addr=%h, want 0 0 40000000", ld_iq, imem_read, imem_address);
        else passed++;
        rst = 1'b0;
        tick();
        exp_pc = 32'h4000_0000;
        exp_fetched = 0;
        exp_stall = 0;
        gen_random(instr, imm, kind);
        run_instr(instr, kind, imm, 1, 1);
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_stall_ack();
        test_flush_drain();
        test_flush_same_cycle();
        test_flush_issue();
        test_decode_sweep();
        test_reset_in_issue();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
